fetch_inst_queue: RTL and testbench
===================================

# fetch_inst_queue

Instruction queue between the FETCH stage and decode in the BEAN RISC-V core. It buffers up to DEPTH fetched (pc, command) pairs so that fetch can run ahead of decode stalls. It drops all buffered entries on a pipeline redirect (branch, jump or trap). Decode always consumes the oldest entry first, through a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  redirect; discards all entries and any same-cycle enqueue
- in_valid  input  1  FETCH presents a valid pair
- in_ready  output  1  queue accepts; equals !full; no combinational dependence on out_ready
- in_pc  input  `XPR_LEN  PC of the fetched instruction
- in_command  input  `INST_LEN  fetched instruction word
- out_valid  output  1  queue non-empty
- out_ready  input  1  decode consumes the head entry
- out_pc  output  `XPR_LEN  head PC; 0 when empty
- out_command  output  `INST_LEN  head instruction; `NOP_INST (32'h00000013) when empty
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer of DEPTH entries with read pointer rd_ptr and write pointer wr_ptr, each $clog2(DEPTH) bits wide. Both pointers wrap modulo DEPTH by natural overflow.
- Occupancy is held in a count register. full = (count == DEPTH) and empty = (count == 0).
- An enqueue fires when in_valid && in_ready && !flush. It writes mem[wr_ptr] and increments wr_ptr.
- A dequeue fires when out_valid && out_ready && !flush. It increments rd_ptr.
- Occupancy update:
  - count increments on enqueue only.
  - count decrements on dequeue only.
  - count is unchanged when both fire in the same cycle.
- Flush has priority over everything. On flush, rd_ptr, wr_ptr and count go to 0. The same-cycle enqueue and dequeue are suppressed, and storage contents are left unchanged.
- Reset behaves exactly like flush. Every output takes its reset value on the next edge:
  - out_valid = 0
  - count = 0
  - in_ready = 1
  - out_pc = 0
  - out_command = `NOP_INST
- Reset asserted in the middle of traffic drops all entries. No partial state survives.
- Full queue: in_ready = 0 even when out_ready = 1 in the same cycle. This keeps in_ready registered-path clean and costs one bubble.
- Empty queue: there is no bypass. An entry becomes visible at the output the cycle after it is enqueued.
- The head output is combinational from mem[rd_ptr], gated by empty to give the NOP / 0 values.
- in_pc and in_command are not checked. Alignment and illegal-instruction handling belong to decode.

## Timing
- Enqueue-to-out_valid latency is 1 cycle.
- Dequeue-to-next-head is 1 cycle. Back-to-back dequeues sustain 1 entry per cycle.
- Steady-state throughput is 1 instruction per cycle, with the queue neither full nor empty.
- in_ready and out_valid depend only on registered state, so they are glitch-free with respect to the partner's handshake inputs.
- Flush at edge N: out_valid = 0 and count = 0 from cycle N+1. An in_valid presented at cycle N+1 is accepted normally.

## Structure
- BEAN.cfg holds the shared constants:
  - `XPR_LEN
  - `INST_LEN (32)
  - `NOP_INST (32'h00000013, addi x0,x0,0)
- No new typedefs are needed.
- One sub-module is natural: fetch_queue_ram.
  - DEPTH x (`XPR_LEN + `INST_LEN) register array.
  - Single write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Contains no reset logic.
- fetch_inst_queue keeps the pointers, count and handshake logic.

## Test plan
- **Reset:** assert reset for 2 cycles with in_valid = 1 → after release, out_valid = 0, count = 0, in_ready = 1, out_command = 32'h00000013, out_pc = 0.
- **Fill and drain:** with out_ready = 0, enqueue pc 0x100/0x104/0x108/0x10C → count = 4, in_ready = 0. A 5th in_valid is not accepted. Then out_ready = 1 → heads 0x100..0x10C appear in order on 4 consecutive cycles, then out_valid = 0.
- **Simultaneous enqueue/dequeue:** with count = 2, in_valid = 1 and out_ready = 1 for 10 cycles → count stays 2 and output order matches input order.
- **Wrap-around:** stream 12 entries at 1/cycle with out_ready toggling 1,0 → all 12 PCs emerge in order, none lost or duplicated, and count never exceeds 4.
- **Flush:** with count = 3, assert flush together with in_valid (pc 0x200) and out_ready → next cycle count = 0 and out_valid = 0. 0x200 is not present. An enqueue of 0x300 the following cycle appears at the head one cycle later.
- **Full with ready:** with count = 4 and out_ready = 1 plus in_valid = 1 in the same cycle → in_ready = 0 in that cycle and count = 3 next cycle.

Source files
------------

// File: rtl/fetch_inst_queue_pkg.sv
// Shared core constants used by the fetch instruction queue and its storage.
package fetch_inst_queue_pkg;
   localparam int XPR_LEN  = 32;
   localparam int INST_LEN = 32;
   localparam logic [INST_LEN-1:0] NOP_INST = 32'h00000013;
endpackage

// File: rtl/fetch_queue_ram.sv
// Register-array storage for the fetch queue: one write port, one asynchronous read port.
module fetch_queue_ram
   import fetch_inst_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = XPR_LEN + INST_LEN
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Head must be visible in the same cycle its pointer moves, so the read is combinational.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_inst_queue.sv
// FETCH-to-decode instruction queue: circular buffer with valid/ready on both sides and flush.
module fetch_inst_queue
   import fetch_inst_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XPR_LEN-1:0]         in_pc,
   input  logic [INST_LEN-1:0]        in_command,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XPR_LEN-1:0]         out_pc,
   output logic [INST_LEN-1:0]        out_command,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = XPR_LEN + INST_LEN;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full, empty, enq, deq;
   logic [DW-1:0] head;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // Readiness comes from registered occupancy only; a full queue stalls even if decode drains.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign enq       = in_valid && in_ready && !flush;
   assign deq       = out_valid && out_ready && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CW'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_ram (
      .clk   (clk),
      .we    (enq && !reset),
      .waddr (wr_ptr_q),
      .wdata ({in_pc, in_command}),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   assign out_pc      = empty ? '0 : head[DW-1:INST_LEN];
   assign out_command = empty ? NOP_INST : head[INST_LEN-1:0];
   assign count       = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench for fetch_inst_queue: a reference queue predicts every output each cycle.
module tb_fetch_inst_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_command = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_command;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;
   bit known = 1'b0;
   logic [63:0] sb [$];

   always #5 clk = ~clk;

   fetch_inst_queue #(.DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_command  (in_command),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_command (out_command),
      .count       (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] cmd_of(input logic [31:0] pc);
      return pc ^ 32'h1234_0013;
   endfunction

   // One clock of stimulus: drive, check model-predicted outputs at negedge, then advance the model.
   task automatic step(input bit iv, input logic [31:0] pc, input bit ordy, input bit fl, input bit rst);
      bit m_enq, m_deq;
      logic [63:0] head;
      in_valid   = iv;
      in_pc      = pc;
      in_command = cmd_of(pc);
      out_ready  = ordy;
      flush      = fl;
      reset      = rst;
      @(negedge clk);
      head = (sb.size() > 0) ? sb[0] : {32'h0, 32'h00000013};
      if (known) begin
         check("count", 64'(count), 64'(sb.size()));
         check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
         check("in_ready", 64'(in_ready), 64'(sb.size() < 4));
         check("out_pc", 64'(out_pc), 64'(head[63:32]));
         check("out_command", 64'(out_command), 64'(head[31:0]));
      end
      m_enq = iv && (sb.size() < 4) && !fl;
      m_deq = ordy && (sb.size() > 0) && !fl;
      @(posedge clk);
      #1;
      if (rst || fl) begin
         sb.delete();
         $display("t=%0t clear (reset=%0b flush=%0b)", $time, rst, fl);
      end else begin
         if (m_deq) begin
            $display("t=%0t deq pc=%h cmd=%h", $time, sb[0][63:32], sb[0][31:0]);
            void'(sb.pop_front());
         end
         if (m_enq) begin
            sb.push_back({pc, cmd_of(pc)});
            $display("t=%0t enq pc=%h", $time, pc);
         end
      end
      known = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int idx;
      #1;
      // Reset held two cycles while fetch presents data
      step(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h54, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Fill, reject a fifth, then drain in order
      for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
      drain();

      // Simultaneous enqueue/dequeue at occupancy 2
      step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 32'h408 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      drain();

      // Wrap-around: 12 entries with out_ready toggling
      idx = 0;
      for (int i = 0; i < 40 && idx < 12; i++) begin
         bit acc;
         acc = (sb.size() < 4);
         step(1'b1, 32'h500 + 32'(4 * idx), (i % 2) == 0, 1'b0, 1'b0);
         if (acc) idx++;
      end
      check("wrap_all_sent", 64'(idx), 64'd12);
      drain();

      // Flush with same-cycle enqueue and dequeue
      for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Full with out_ready: no enqueue that cycle
      for (int i = 0; i < 4; i++) step(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h7F0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Reset in the middle of traffic
      step(1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h804, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h808, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h80C, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0, 1'b0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
